muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller for the HI/LO special-register path of the single-cycle MIPS core. It accepts MULT, MULTU, DIV and DIVU requests from the decoder. Each operation runs as a 32-iteration shift-add or restoring-divide loop and returns a 64-bit {HI,LO} result with a one-cycle write strobe for the highlow register. It also drives a stall so that a new mult/div or an MFHI/MFLO cannot proceed while an operation is in flight.

---
 rtl/muldiv_sequencer_if.sv | 23 ++
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Decoder-side handshake bundle for the iterative multiply/divide unit that feeds HI/LO.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     srca;
  logic [WIDTH-1:0]     srcb;
  logic                 mf_req;
  logic                 flush;
  logic                 busy;
  logic                 stall;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, op, srca, srcb, mf_req, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, srca, srcb, mf_req, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: shift-add multiply, restoring divide,
// sign fix-up, then a one-cycle {HI,LO} write strobe. Stalls the core while in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] x);
    return ~x + DW'(1);
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [DW-1:0]      result_q, result_d;

  logic               sign_a_s, sign_b_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH+1:0]   div_diff_s;
  logic               div_ge_s;
  logic [DW-1:0]      prod_s;

  // Datapath helpers: operand magnitudes and one iteration of each loop.
  always_comb begin
    sign_a_s    = ~bus.op[0] & bus.srca[WIDTH-1];
    sign_b_s    = ~bus.op[0] & bus.srcb[WIDTH-1];
    mag_a_s     = sign_a_s ? neg_w(bus.srca) : bus.srca;
    mag_b_s     = sign_b_s ? neg_w(bus.srcb) : bus.srcb;
    mul_sum_s   = hi_q + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Remainder stays below the divisor, so one extra bit holds the shifted value
    // and a second extra bit exposes the borrow of the trial subtract.
    div_shift_s = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_q};
    div_ge_s    = ~div_diff_s[WIDTH+1];
    prod_s      = {hi_q[WIDTH-1:0], lo_q};
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;

    if (bus.flush && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        // DONE accepts a waiting start on its exit edge, exactly like IDLE.
        IDLE, DONE: begin
          if (bus.start) begin
            div_d    = bus.op[1];
            cnt_d    = {CW{1'b0}};
            hi_d     = {(WIDTH+1){1'b0}};
            neg_lo_d = sign_a_s ^ sign_b_s;
            neg_hi_d = sign_a_s;
            if (bus.op[1]) begin
              lo_d = mag_a_s;
              b_d  = mag_b_s;
            end else begin
              lo_d = mag_b_s;
              b_d  = mag_a_s;
            end
            if (bus.op[1] && (bus.srcb == {WIDTH{1'b0}})) begin
              result_d = {bus.srca, {WIDTH{1'b1}}};
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          if (div_q) begin
            hi_d = div_ge_s ? div_diff_s[WIDTH:0] : div_shift_s;
            lo_d = {lo_q[WIDTH-2:0], div_ge_s};
          end else begin
            hi_d = {1'b0, mul_sum_s[WIDTH:1]};
            lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        FIX: begin
          if (div_q) begin
            result_d = {neg_hi_q ? neg_w(hi_q[WIDTH-1:0]) : hi_q[WIDTH-1:0],
                        neg_lo_q ? neg_w(lo_q) : lo_q};
          end else begin
            result_d = neg_lo_q ? neg_dw(prod_s) : prod_s;
          end
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= {(WIDTH+1){1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      result_q <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.stall  = (state_q != IDLE) & (bus.start | bus.mf_req);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, random ops against
// an arithmetic reference model, flush/reset aborts, stall behaviour and back-to-back ops.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'b00:   return 64'(sa * sb);
      2'b01:   return 64'(ua * ub);
      2'b10:   return {32'(sa % sb), 32'(sa / sb)};
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Presents one op, then samples #1 after each edge until busy drops (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int done_at, output int busy_cnt,
                        output int done_cnt);
    bus.op = o; bus.srca = a; bus.srcb = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    res = 64'd0; done_at = -1; busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (!bus.busy) break;
      busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at = k;
        res = bus.result;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.op = 2'b01; bus.srca = 32'd5; bus.srcb = 32'd6;
    bus.mf_req = 1'b1; bus.flush = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: busy=%b stall=%b done=%b required 0 0 0", bus.busy, bus.stall, bus.done);
    end
    n_cmp++;
    if (bus.result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_result: got %h required 0", bus.result);
    end
    bus.start = 1'b0; bus.mf_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9,
                             32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd2,
                             32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] exp [7] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                             64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_1234_FFFF_FFFF, 64'h0000_0000_8000_0000,
                             64'h4000_0000_0000_0000};
    logic [63:0] res;
    int done_at, busy_cnt, done_cnt, exp_at;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], res, done_at, busy_cnt, done_cnt);
      exp_at = (i == 4) ? 0 : 33;
      n_cmp++;
      if (res !== exp[i] || done_cnt != 1) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got %h (%0d pulses) required %h (1 pulse)", i, res, done_cnt, exp[i]);
      end
      n_cmp++;
      if (done_at != exp_at || busy_cnt != exp_at + 1) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: done_at=%0d busy=%0d required %0d %0d", i, done_at, busy_cnt, exp_at, exp_at + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] res, exp;
    int done_at, busy_cnt, done_cnt, exp_at;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      exp = model(o, a, b);
      exp_at = (o[1] && b == 32'd0) ? 0 : 33;
      run_op(o, a, b, res, done_at, busy_cnt, done_cnt);
      n_cmp++;
      if (res !== exp || done_cnt != 1 || done_at != exp_at || busy_cnt != exp_at + 1) begin
        n_bad++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got %h at %0d busy=%0d, required %h at %0d busy=%0d",
                 i, o, a, b, res, done_at, busy_cnt, exp, exp_at, exp_at + 1);
      end
    end
  endtask

  task automatic test_flush();
    logic [63:0] held;
    int dones;
    held = bus.result;
    // flush while idle must not block a simultaneous start
    bus.op = 2'b01; bus.srca = 32'd9; bus.srcb = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_idle: busy=%b required 1", bus.busy);
    end
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_abort: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) dones++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dones != 0 || bus.result !== held) begin
      n_bad++;
      $display("FAIL flush_quiet: activity=%0d result=%h required 0 %h", dones, bus.result, held);
    end
  endtask

  task automatic test_reset_midop();
    int act;
    bus.op = 2'b00; bus.srca = 32'd1234; bus.srcb = 32'd77; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0; bus.flush = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result !== 64'd0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midop: busy=%b done=%b result=%h required 0 0 0", bus.busy, bus.done, bus.result);
    end
    reset = 1'b1; bus.flush = 1'b0; bus.start = 1'b0;
    act = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) act++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL reset_no_complete: activity cycles=%0d required 0", act);
    end
  endtask

  task automatic test_stall_mf();
    int stall_cnt;
    logic stall_done, stall_after;
    stall_cnt = 0; stall_done = 1'b0; stall_after = 1'b1;
    n_cmp++;
    bus.mf_req = 1'b1;
    #1;
    if (bus.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_idle: stall=%b required 0", bus.stall);
    end
    bus.op = 2'b11; bus.srca = 32'd1000; bus.srcb = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 36; k++) begin
      if (bus.stall) stall_cnt++;
      if (k == 33) stall_done = bus.stall;
      if (k == 34) stall_after = bus.stall;
      @(posedge clk); #1;
    end
    bus.mf_req = 1'b0;
    n_cmp++;
    if (stall_cnt != 34 || stall_done !== 1'b1 || stall_after !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_mf: cycles=%0d in_done=%b after=%b required 34 1 0", stall_cnt, stall_done, stall_after);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_a, exp_b, res_a, res_b;
    int busy_cnt, first_idle, done_cnt, done1, done2;
    exp_a = model(2'b00, 32'hFFFF_0123, 32'd4567);
    exp_b = model(2'b10, 32'hDEAD_BEEF, 32'd12345);
    bus.op = 2'b00; bus.srca = 32'hFFFF_0123; bus.srcb = 32'd4567; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt = 0; first_idle = -1; done_cnt = 0; done1 = -1; done2 = -1;
    res_a = 64'd0; res_b = 64'd0;
    for (int k = 0; k < 120; k++) begin
      if (bus.busy) busy_cnt++;
      else if (first_idle < 0) first_idle = k;
      if (bus.done) begin
        done_cnt++;
        if (done1 < 0) begin done1 = k; res_a = bus.result; end
        else begin done2 = k; res_b = bus.result; end
      end
      if (k == 10) begin
        bus.op = 2'b10; bus.srca = 32'hDEAD_BEEF; bus.srcb = 32'd12345; bus.start = 1'b1;
      end
      if (k == 34) bus.start = 1'b0;
      if (first_idle >= 0) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done1 != 33 || res_a !== exp_a) begin
      n_bad++;
      $display("FAIL b2b_first: done_at=%0d result=%h required 33 %h", done1, res_a, exp_a);
    end
    n_cmp++;
    if (done2 != 67 || res_b !== exp_b || done_cnt != 2) begin
      n_bad++;
      $display("FAIL b2b_second: done_at=%0d result=%h pulses=%0d required 67 %h 2", done2, res_b, done_cnt, exp_b);
    end
    n_cmp++;
    if (busy_cnt != 68 || first_idle != 68) begin
      n_bad++;
      $display("FAIL b2b_busy: busy=%0d idle_at=%0d required 68 68", busy_cnt, first_idle);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.srca = 32'd0; bus.srcb = 32'd0;
    bus.mf_req = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_midop();
    test_stall_mf();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
